ysyx_22040895_regfile_mp: RTL
=============================

// Module: ysyx_22040895_regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a built-in scoreboard and a self-clearing init sequence.
//  Sits between decode (read + allocate) and writeback (write) in the core datapath.
//  x0 reads as zero and is never marked busy.
//  Reads are combinational. Writes and busy updates take effect at the rising edge.
// PARAMETERS
//  XLEN  64  data width of each register
//  NREG  32  register count; power of 2, >= 4
//  NRD   2   read ports
//  NWR   1   write ports; higher port index has priority
//  AW    $clog2(NREG)  address width (derived)
// PORTS
//  clk          in   1         core clock
//  rst          in   1         synchronous, active-high reset
//  ready_o      out  1         init sequence finished; file usable
//  re_i         in   NRD       per-port read enable
//  raddr_i      in   NRD*AW    packed read addresses; port k at [k*AW +: AW]
//  rdata_o      out  NRD*XLEN  packed read data
//  rbusy_o      out  NRD       read register has a pending producer
//  we_i         in   NWR       per-port write enable
//  waddr_i      in   NWR*AW    packed write addresses
//  wdata_i      in   NWR*XLEN  packed write data
//  alloc_i      in   1         mark alloc_addr_i busy (new producer issued)
//  alloc_addr_i in   AW        destination to mark busy
// BEHAVIOUR
//  Reset values
//   - rst high: state=INIT, clear pointer=1, ready_o=0, all busy bits 0.
//   - Asserting rst mid-operation, including mid-INIT, restarts the clear at register 1.
//  State machine INIT -> RUN
//   - INIT: each edge with rst low zeroes regs[ptr] and increments ptr.
//   - The edge that clears NREG-1 moves to RUN, so ready_o rises NREG-1 edges after rst falls.
//   - In INIT: we_i and alloc_i are ignored; rdata_o=0; rbusy_o=0.
//   - RUN is held until rst.
//  Reads
//   - rdata_o[k]=0 if re_i[k]=0, raddr=0 or ready_o=0; otherwise regs[raddr].
//   - rbusy_o[k]=busy[raddr] under the same gating.
//  Writes
//   - we_i[j] with waddr!=0 writes wdata at the edge and clears busy[waddr].
//   - If two ports hit the same address, the highest j wins.
//   - A write to x0 is dropped.
//  Allocate
//   - alloc_i with addr!=0 sets busy[addr] at the edge.
//   - Alloc and write to the same addr in the same cycle: busy ends 1, data is still written (new producer wins).
//   - Alloc of an already-busy register keeps it busy; no error is raised.
// CONFIGURATION
//  YSYX_22040895_RF_BYPASS_EN defined
//   - A read matching an active write address in the same cycle returns the winning wdata_i.
//   - rbusy_o shows 0 for that read unless alloc_i targets the same address.
//  Not defined
//   - The read returns the pre-edge register value and busy bit; the write is visible the next cycle.
//  x0 and INIT gating apply in both builds.
// STRUCTURE
//  Package ysyx_22040895_rf_pkg holds:
//   - XLEN and NREG defaults
//   - the rf_state_e enum {RF_INIT, RF_RUN}
//   - a function for write-port priority select
//  Sub-module ysyx_22040895_rf_scoreboard holds the NREG busy bits and the alloc/clear/priority rules.
//  The top level keeps the data array, the INIT FSM and the read muxes.
// TESTING
//  1. Release rst with NREG=32 -> ready_o=0 for 31 edges, 1 after the 31st; every read returns 0.
//  2. Assert rst at init edge 10, release, poll ready_o -> 31 more edges needed; regs 1..31 read 0 once ready.
//  3. NWR=2: we=2'b11, both waddr=5, wdata0=0x11, wdata1=0x22 -> x5 reads 0x22 next cycle.
//     Write x0=0xFF -> x0 reads 0.
//  4. alloc x7 -> rbusy=1; writeback x7=0xAB -> rbusy=0, data 0xAB.
//     alloc+write x7 in the same cycle -> rbusy stays 1.
//  5. Same-cycle write x3=0x55 and read x3 (old value 0x0):
//     BYPASS_EN -> rdata=0x55, rbusy=0; not defined -> rdata=0x0, 0x55 next cycle.
//  6. re_i=0 on port 1 while x9=0x99 -> rdata_o port 1 = 0 and rbusy_o port 1 = 0.

Source files
------------

// File: rtl/ysyx_22040895_rf_pkg.sv
// Shared defaults, FSM state type and write-port priority helper for the register file.
package ysyx_22040895_rf_pkg;

  localparam int unsigned RF_XLEN   = 64;
  localparam int unsigned RF_NREG   = 32;
  // Widest write-port hit vector the priority helper accepts.
  localparam int unsigned RF_MAX_WR = 8;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  // Index of the highest set bit; later write ports win a same-address collision.
  function automatic int unsigned rf_prio_sel(input logic [RF_MAX_WR-1:0] hits);
    int unsigned sel;
    sel = 0;
    for (int unsigned j = 0; j < RF_MAX_WR; j++) begin
      if (hits[j]) sel = j;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_22040895_rf_scoreboard.sv
// Busy bits for the register file: alloc sets, writeback clears, alloc wins a same-cycle tie.
module ysyx_22040895_rf_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NWR  = 1,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_addr_i,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    if (run_i) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (we_i[j]) w_busy_next[waddr_i[j*AW +: AW]] = 1'b0;
      end
      if (alloc_i) w_busy_next[alloc_addr_i] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/ysyx_22040895_regfile_mp.sv
// Multi-port register file with scoreboard and self-clearing init sequence.
// Define YSYX_22040895_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module ysyx_22040895_regfile_mp
  import ysyx_22040895_rf_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned NREG = RF_NREG,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic [NRD-1:0]      re_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic                alloc_i,
  input  logic [AW-1:0]       alloc_addr_i
);

  rf_state_e            r_state;
  rf_state_e            w_state_next;
  logic                 w_run;
  logic [AW-1:0]        r_ptr;
  logic [XLEN-1:0]      r_regs [NREG];
  logic [NREG-1:0]      w_busy;
  logic [RF_MAX_WR-1:0] w_hit [NREG];

  always_ff @(posedge clk) begin
    if (rst) r_state <= RF_INIT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == RF_INIT && r_ptr == AW'(NREG - 1)) w_state_next = RF_RUN;
  end

  always_comb begin
    w_run   = (r_state == RF_RUN);
    ready_o = w_run;
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_ptr <= AW'(1);
    else if (r_state == RF_INIT) r_ptr <= r_ptr + AW'(1);
  end

  // Per-register write-port hit vectors, shared by the write path and the bypass.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_hit[i] = '0;
      for (int unsigned j = 0; j < NWR; j++) begin
        w_hit[i][j] = we_i[j] && (waddr_i[j*AW +: AW] == AW'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RF_INIT) begin
        r_regs[r_ptr] <= '0;
      end else begin
        for (int unsigned i = 1; i < NREG; i++) begin
          if (|w_hit[i]) r_regs[i] <= wdata_i[rf_prio_sel(w_hit[i])*XLEN +: XLEN];
        end
      end
    end
  end

  ysyx_22040895_rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .run_i        (w_run),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .alloc_i      (alloc_i),
    .alloc_addr_i (alloc_addr_i),
    .busy_o       (w_busy)
  );

  always_comb begin
    logic [AW-1:0] ra;
    rdata_o = '0;
    rbusy_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = raddr_i[k*AW +: AW];
      if (re_i[k] && ra != '0 && w_run) begin
`ifdef YSYX_22040895_RF_BYPASS_EN
        if (|w_hit[ra]) begin
          rdata_o[k*XLEN +: XLEN] = wdata_i[rf_prio_sel(w_hit[ra])*XLEN +: XLEN];
          rbusy_o[k]              = alloc_i && (alloc_addr_i == ra);
        end else begin
          rdata_o[k*XLEN +: XLEN] = r_regs[ra];
          rbusy_o[k]              = w_busy[ra];
        end
`else
        rdata_o[k*XLEN +: XLEN] = r_regs[ra];
        rbusy_o[k]              = w_busy[ra];
`endif
      end
    end
  end

endmodule
